// File: rtl/bit_ser_pkg.sv
// Shared types and sizing helpers for the bit serializer.
// Build option: define BIT_SER_MSB_FIRST_EN to send bit WIDTH-1 first.
package bit_ser_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_BITS  = $clog2(DEF_WIDTH);

    // Bit-counter width for a given frame width; never narrower than one bit.
    function automatic int cnt_bits(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/bit_ser_hold.sv
// One-entry word buffer between the load handshake and the shifter.
module bit_ser_hold
    import bit_ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;

    // A write wins over a same-cycle read so a refill keeps the buffer full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (clr_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (wr_en_i) begin
            full_q <= 1'b1;
            data_q <= wr_data_i;
        end else if (rd_en_i) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_q;
        end
    end

    assign rd_data_o = data_q;
    assign full_o    = full_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: buffered word handshake, gapless bit stream, frame counter.
// Build option: BIT_SER_MSB_FIRST_EN selects MSB-first order (default LSB-first).
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    output logic             x_out_o,
    output logic             bit_valid_o,
    output logic             frame_last_o,
    output logic [CNT_W-1:0] frames_sent_o
);

    localparam int            CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             x_out_q, x_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_last_q, frame_last_d;
    logic             hold_full_s, rd_en_s, wr_en_s;
    logic [WIDTH-1:0] hold_data_s;

    assign wr_en_s = load_valid_i & ~hold_full_s & ~flush_i;

    bit_ser_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (flush_i),
        .wr_en_i   (wr_en_s),
        .wr_data_i (load_data_i),
        .rd_en_i   (rd_en_s),
        .rd_data_o (hold_data_s),
        .full_o    (hold_full_s)
    );

    // Next-state: frame sequencing, shifter advance and output pre-computation.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        frames_d = frames_q;
        rd_en_s  = 1'b0;
        if (flush_i) begin
            state_d = ST_IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_s) begin
                        state_d = ST_SHIFT;
                        shift_d = hold_data_s;
                        cnt_d   = '0;
                        rd_en_s = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == LAST) begin
                        frames_d = frames_q + CNT_W'(1);
                        cnt_d    = '0;
                        if (hold_full_s) begin
                            shift_d = hold_data_s;
                            rd_en_s = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            shift_d = '0;
                        end
                    end else begin
`ifdef BIT_SER_MSB_FIRST_EN
                        shift_d = shift_q << 1;
`else
                        shift_d = shift_q >> 1;
`endif
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs are registered, so they are derived from the next state.
        bit_valid_d  = (state_d == ST_SHIFT);
`ifdef BIT_SER_MSB_FIRST_EN
        x_out_d      = bit_valid_d & shift_d[WIDTH-1];
`else
        x_out_d      = bit_valid_d & shift_d[0];
`endif
        frame_last_d = bit_valid_d & (cnt_d == LAST);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            frames_q     <= '0;
            x_out_q      <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            frames_q     <= frames_d;
            x_out_q      <= x_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_last_q <= frame_last_d;
        end
    end

    assign load_ready_o  = ~hold_full_s;
    assign x_out_o       = x_out_q;
    assign bit_valid_o   = bit_valid_q;
    assign frame_last_o  = frame_last_q;
    assign frames_sent_o = frames_q;

endmodule
